bram_ctrl: RTL and testbench

//   Initiator side of the binary RAM cell interface (select / rdwr / in / out).

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_ctrl_if.sv | 30 +++
 rtl/bram_addr_dec.sv | 20 ++
 rtl/bram_ctrl.sv | 120 ++++++++++++
 tb/tb_bram_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
// Shared types and constants for the binary RAM cell controller.
package bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    HOLD,
    VRD,
    VCHK,
    DONE
  } state_t;

  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

endpackage

// File: rtl/bram_ctrl_if.sv
// Host request/ack bus plus the cell-array select/rdwr/in/out wires.
// master: host and cell array side; slave: the controller.
interface bram_ctrl_if #(
  parameter int unsigned DW    = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
);
  logic             req;
  logic             wr;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic             ack;
  logic [DW-1:0]    rdata;
  logic             busy;
  logic             err;
  logic [DEPTH-1:0] ram_sel;
  logic             ram_rdwr;
  logic [DW-1:0]    ram_in;
  logic [DW-1:0]    ram_out;

  modport master (
    output req, wr, addr, wdata, ram_out,
    input  ack, rdata, busy, err, ram_sel, ram_rdwr, ram_in
  );

  modport slave (
    input  req, wr, addr, wdata, ram_out,
    output ack, rdata, busy, err, ram_sel, ram_rdwr, ram_in
  );
endinterface

// File: rtl/bram_addr_dec.sv
// Word address to one-hot select decoder with enable and range flag.
module bram_addr_dec #(
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [DEPTH-1:0] sel,
  output logic             out_of_range
);

  always_comb begin
    sel          = '0;
    out_of_range = (32'(addr) >= DEPTH);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (en && (addr == AW'(i))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_ctrl.sv
// Initiator for a DEPTH x DW binary RAM cell array: req/ack host side, select/rdwr/in/out cells.
// Optional BRAM_CTRL_VERIFY_EN adds a read-back check after every write.
module bram_ctrl
  import bram_pkg::*;
#(
  parameter int unsigned DW    = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  bram_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic             wr_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic             err_q;

  logic             drive;
  logic             rdwr;
  logic [DW-1:0]    ram_in;
  logic             ack;
  logic             err_upd;
  logic             err_d;
  logic [DEPTH-1:0] sel;
  logic             oor;

  bram_addr_dec #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_dec (
    .addr         (addr_q),
    .en           (drive),
    .sel          (sel),
    .out_of_range (oor)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req) begin
        wr_q    <= bus.wr;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      // Cells are sampled on the edge leaving HOLD.
      if (state_q == HOLD && !wr_q) rdata_q <= oor ? '0 : bus.ram_out;
      if (err_upd) err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drive   = 1'b0;
    rdwr    = RAM_RD;
    ram_in  = '0;
    ack     = 1'b0;
    err_upd = 1'b0;
    err_d   = oor;
    unique case (state_q)
      IDLE: if (bus.req) state_d = DRIVE;
      DRIVE, HOLD: begin
        drive  = 1'b1;
        rdwr   = wr_q ? RAM_WR : RAM_RD;
        ram_in = wr_q ? wdata_q : '0;
        if (state_q == DRIVE) begin
          state_d = HOLD;
        end else begin
`ifdef BRAM_CTRL_VERIFY_EN
          if (wr_q) begin
            state_d = VRD;
          end else begin
            state_d = DONE;
            err_upd = 1'b1;
          end
`else
          state_d = DONE;
          err_upd = 1'b1;
`endif
        end
      end
`ifdef BRAM_CTRL_VERIFY_EN
      VRD: begin
        drive   = 1'b1;
        state_d = VCHK;
      end
      VCHK: begin
        drive   = 1'b1;
        err_upd = 1'b1;
        err_d   = (bus.ram_out != wdata_q) | oor;
        state_d = DONE;
      end
`endif
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack      = ack;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;
  assign bus.ram_sel  = sel;
  assign bus.ram_rdwr = rdwr;
  assign bus.ram_in   = ram_in;

endmodule

// File: tb/tb_bram_ctrl.sv
// Randomized bench for bram_ctrl with a cell-array model and a transaction-level reference.
module tb_bram_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 3;
`ifdef BRAM_CTRL_VERIFY_EN
  localparam bit          VERIFY     = 1'b1;
  localparam logic [DW-1:0] STUCK_MASK = 4'b1110;
`else
  localparam bit          VERIFY     = 1'b0;
  localparam logic [DW-1:0] STUCK_MASK = 4'b1111;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_ctrl_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

  bram_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Cell array: written while selected in write mode, outputs OR of selected words.
  logic [DW-1:0] cell_mem [DEPTH];
  always_comb begin
    bus.ram_out = '0;
    for (int i = 0; i < DEPTH; i++) if (bus.ram_sel[i]) bus.ram_out = bus.ram_out | cell_mem[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (bus.ram_sel[i] && !bus.ram_rdwr) cell_mem[i] <= bus.ram_in & STUCK_MASK;
  end

  // Reference state.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   edges;
    int   k;
    bit   got_ack;
    bit   oor;
    int   exp_lat;
    logic [DEPTH-1:0] exp_sel;
    oor     = (int'(a) >= DEPTH);
    exp_sel = oor ? '0 : DEPTH'(1) << a;
    exp_lat = (w && VERIFY) ? 5 : 3;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    // Junk on the request inputs while busy must be ignored.
    bus.req = 1'b0; bus.wr = 1'($urandom); bus.addr = AW'($urandom); bus.wdata = DW'($urandom);
    edges = 1; k = 0; got_ack = 0;
    for (int i = 0; i < 12 && !got_ack; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        got_ack = 1;
      end else begin
        k++;
        check("busy", bus.busy, 1);
        check("ram_sel", bus.ram_sel, exp_sel);
        check("ram_rdwr", bus.ram_rdwr, (k <= 2 && w) ? 0 : 1);
        if (k <= 2) check("ram_in", bus.ram_in, w ? d : '0);
        bus.wr = 1'($urandom); bus.addr = AW'($urandom); bus.wdata = DW'($urandom);
        @(posedge clk);
        edges++;
      end
    end
    check("ack_seen", got_ack, 1);
    check("latency", edges, exp_lat);
    if (w) begin
      exp_err = oor || (VERIFY && ((d & STUCK_MASK) != d));
      if (!oor) ref_mem[a] = d & STUCK_MASK;
    end else begin
      exp_err   = oor;
      exp_rdata = oor ? '0 : ref_mem[a];
    end
    check("ack_sel", bus.ram_sel, 0);
    check("ack_rdwr", bus.ram_rdwr, 1);
    check("ack_err", bus.err, exp_err);
    check("ack_rdata", bus.rdata, exp_rdata);
    @(negedge clk);
    check("ack_pulse", bus.ack, 0);
    check("idle_busy", bus.busy, 0);
    check("hold_err", bus.err, exp_err);
    check("hold_rdata", bus.rdata, exp_rdata);
  endtask

  initial begin
    int first;
    int second;
    int cyc;
    bus.req = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cell_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    exp_rdata = '0;
    exp_err   = 0;
    #12;
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_sel", bus.ram_sel, 0);
    check("rst_rdwr", bus.ram_rdwr, 1);
    check("rst_ram_in", bus.ram_in, 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst = 0;

    run_txn(1'b1, 2'd2, 4'hA);
    run_txn(1'b0, 2'd2, 4'h0);

    // Back-to-back reads with req held high.
    @(negedge clk);
    bus.req = 1; bus.wr = 0; bus.addr = 2'd2;
    first = -1; second = -1; cyc = 0;
    for (int i = 0; i < 30 && second < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.ack) begin
        check("b2b_rdata", bus.rdata, ref_mem[2]);
        if (first < 0) first = cyc;
        else begin
          second = cyc;
          bus.req = 0;
        end
      end
    end
    check("b2b_spacing", second - first, 4);
    exp_rdata = ref_mem[2];

    run_txn(1'b0, 2'd3, 4'h0);
    run_txn(1'b1, 2'd1, 4'h5);
    run_txn(1'b0, 2'd1, 4'h0);
    run_txn(1'b1, 2'd1, 4'h4);
    run_txn(1'b0, 2'd1, 4'h0);

    for (int n = 0; n < 40; n++)
      run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));

    // Leave err=1 with nonzero rdata, then reset in the middle of a write.
    run_txn(1'b1, 2'd0, 4'h9);
    run_txn(1'b0, 2'd0, 4'h0);
    run_txn(1'b1, 2'd3, 4'h7);
    @(negedge clk);
    bus.req = 1; bus.wr = 1; bus.addr = 2'd0; bus.wdata = 4'h6;
    @(posedge clk);
    #1;
    check("pre_rst_busy", bus.busy, 1);
    rst = 1; bus.req = 0;
    #1;
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sel", bus.ram_sel, 0);
    check("mid_rst_rdwr", bus.ram_rdwr, 1);
    check("mid_rst_ram_in", bus.ram_in, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    check("mid_rst_err", bus.err, 0);
    exp_rdata = '0;
    exp_err   = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_ack", bus.ack, 0);
    end
    run_txn(1'b0, 2'd0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
